// File: rtl/tick_counter_pkg.sv
// Shared constants and helpers for the tick_counter block.
// No logic; direction/mode encodings and divider-width sizing only.
package tick_counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Smallest width whose range strictly exceeds clock_div.
  function automatic int div_width(input int clock_div);
    return $clog2(clock_div + 1);
  endfunction

endpackage

// File: rtl/clk_tick_gen.sv
// Step divider: counts enabled cycles 0..CLOCK_DIV-1 and flags the last one.
// Latency: step is combinational from the divider register; no backpressure.
// clear forces the divider to 0; enable low freezes it, including at the last value.
module clk_tick_gen #(
  parameter int CLOCK_DIV = 10_000_000,
  parameter int DIV_WIDTH = 24
) (
  input  logic CLOCK_50,
  input  logic KEY0,
  input  logic enable,
  input  logic clear,
  output logic step
);

  localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(CLOCK_DIV - 1);

  logic [DIV_WIDTH-1:0] div_cnt_q, div_cnt_d;

  assign step = enable && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear)       div_cnt_d = '0;
    else if (step)   div_cnt_d = '0;
    else if (enable) div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) div_cnt_q <= '0;
    else       div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/tick_counter.sv
// Up/down wrap/saturate counter stepped every CLOCK_DIV enabled cycles; all outputs registered.
// Latency: load visible 1 cycle after sampling (3 with TICK_COUNTER_LOAD_SYNC_EN); step on the divider edge.
// No backpressure; priority is reset > load > step > hold.
module tick_counter
  import tick_counter_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int CLOCK_DIV = 10_000_000,
  parameter int DIV_WIDTH = div_width(CLOCK_DIV)
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             up_down,
  input  logic             sat_mode,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             term
);

  logic load_eff;
  logic step;

`ifdef TICK_COUNTER_LOAD_SYNC_EN
  // load may come straight from a key or switch; load_value is assumed stable meanwhile.
  logic load_s1_q, load_s1_d, load_s2_q, load_s2_d;

  always_comb begin
    load_s1_d = load;
    load_s2_d = load_s1_q;
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      load_s1_q <= 1'b0;
      load_s2_q <= 1'b0;
    end else begin
      load_s1_q <= load_s1_d;
      load_s2_q <= load_s2_d;
    end
  end

  assign load_eff = load_s2_q;
`else
  assign load_eff = load;
`endif

  clk_tick_gen #(
    .CLOCK_DIV (CLOCK_DIV),
    .DIV_WIDTH (DIV_WIDTH)
  ) u_clk_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .enable   (enable),
    .clear    (load_eff),
    .step     (step)
  );

  logic [WIDTH-1:0] count_q, count_d;
  logic             tick_q, tick_d;
  logic             term_q, term_d;

  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    term_d  = 1'b0;
    if (load_eff) begin
      count_d = load_value;
    end else if (step) begin
      tick_d = 1'b1;
      if (up_down == DIR_UP) begin
        if (count_q == {WIDTH{1'b1}}) begin
          term_d = 1'b1;
          if (sat_mode == MODE_WRAP) count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          term_d = 1'b1;
          if (sat_mode != MODE_SAT) count_d = {WIDTH{1'b1}};
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      term_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
      term_q  <= term_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign term  = term_q;

endmodule
